// File: rtl/inning_scoreboard.sv
// Inning scoreboard: consumes settled at-bat results (one-hot hit1..hit4/out),
// advances runners, counts outs and runs, flips half-innings and ends the game.
// All outputs are registered; an accepted swing is visible one edge later.
module inning_scoreboard #(
    parameter int SCORE_W     = 5,
    parameter int MAX_INNING  = 9,
    parameter int EXTRA_LIMIT = 12
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_swing,
    input  logic [4:0]         i_hitout,
    input  logic               i_new_game,
    output logic [2:0]         o_bases,
    output logic [1:0]         o_outs,
    output logic [3:0]         o_inning,
    output logic               o_bottom,
    output logic [SCORE_W-1:0] o_score_away,
    output logic [SCORE_W-1:0] o_score_home,
    output logic               o_side_change,
    output logic               o_game_over,
    output logic               o_bad_input
);

    typedef enum logic [1:0] {S_PLAY, S_CHANGE, S_OVER} state_t;

    localparam logic [3:0]         LP_MAX_INN   = 4'(MAX_INNING);
    localparam logic [3:0]         LP_EXTRA_INN = 4'(EXTRA_LIMIT);
    localparam logic [SCORE_W-1:0] LP_SCORE_MAX = '1;

    state_t             r_state;
    logic [2:0]         r_bases;
    logic [1:0]         r_outs;
    logic [3:0]         r_inning;
    logic               r_bottom;
    logic [SCORE_W-1:0] r_away;
    logic [SCORE_W-1:0] r_home;
    logic               r_side;
    logic               r_over;
    logic               r_bad;

    logic               w_onehot;
    logic [2:0]         w_hit_n;
    logic [7:0]         w_shift;
    logic [2:0]         w_runs;
    logic [SCORE_W-1:0] w_bat_score;
    logic [SCORE_W:0]   w_sum;
    logic [SCORE_W-1:0] w_new_score;
    logic               w_late;
    logic               w_walkoff;

    // Decode the hit, push runners, and work out the saturated batting score.
    always_comb begin
        w_onehot = (i_hitout != 5'd0) && ((i_hitout & (i_hitout - 5'd1)) == 5'd0);
        w_hit_n  = 3'd0;
        if (i_hitout[4]) w_hit_n = 3'd1;
        if (i_hitout[3]) w_hit_n = 3'd2;
        if (i_hitout[2]) w_hit_n = 3'd3;
        if (i_hitout[1]) w_hit_n = 3'd4;
        // batter enters at bit 0; anything shifted past third (bit 3) has scored
        w_shift     = {4'd0, r_bases, 1'b1} << w_hit_n;
        w_runs      = {2'd0, w_shift[7]} + {2'd0, w_shift[6]}
                    + {2'd0, w_shift[5]} + {2'd0, w_shift[4]};
        w_bat_score = r_bottom ? r_home : r_away;
        w_sum       = {1'b0, w_bat_score} + (SCORE_W+1)'(w_runs);
        w_new_score = w_sum[SCORE_W] ? LP_SCORE_MAX : w_sum[SCORE_W-1:0];
        w_late      = (r_inning >= LP_MAX_INN);
        // home takes the lead in a late bottom half: game ends on this hit
        w_walkoff   = r_bottom && w_late && (w_new_score > r_away);
    end

    // Game FSM with all display state registered alongside it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_PLAY;
            r_bases  <= 3'd0;
            r_outs   <= 2'd0;
            r_inning <= 4'd1;
            r_bottom <= 1'b0;
            r_away   <= '0;
            r_home   <= '0;
            r_side   <= 1'b0;
            r_over   <= 1'b0;
            r_bad    <= 1'b0;
        end else if (i_new_game) begin
            r_state  <= S_PLAY;
            r_bases  <= 3'd0;
            r_outs   <= 2'd0;
            r_inning <= 4'd1;
            r_bottom <= 1'b0;
            r_away   <= '0;
            r_home   <= '0;
            r_side   <= 1'b0;
            r_over   <= 1'b0;
            r_bad    <= 1'b0;
        end else begin
            r_bad <= 1'b0;
            case (r_state)
                S_PLAY: begin
                    if (i_swing) begin
                        if (!w_onehot) begin
                            r_bad <= 1'b1;
                        end else if (i_hitout[0]) begin
                            if (r_outs == 2'd2) begin
                                r_outs  <= 2'd0;
                                r_bases <= 3'd0;
                                r_state <= S_CHANGE;
                                r_side  <= 1'b1;
                            end else begin
                                r_outs <= r_outs + 2'd1;
                            end
                        end else begin
                            r_bases <= w_shift[3:1];
                            if (r_bottom) r_home <= w_new_score;
                            else          r_away <= w_new_score;
                            if (w_walkoff) begin
                                r_state <= S_OVER;
                                r_over  <= 1'b1;
                            end
                        end
                    end
                end
                S_CHANGE: begin
                    r_side <= 1'b0;
                    if ((!r_bottom && w_late && (r_home > r_away)) ||
                        (r_bottom && w_late && (r_home != r_away)) ||
                        (r_bottom && (r_inning == LP_EXTRA_INN) && (r_home == r_away))) begin
                        r_state <= S_OVER;
                        r_over  <= 1'b1;
                    end else begin
                        r_state  <= S_PLAY;
                        r_bottom <= ~r_bottom;
                        if (r_bottom) r_inning <= r_inning + 4'd1;
                    end
                end
                default: begin
                    // OVER: board frozen until new_game or reset
                end
            endcase
        end
    end

    assign o_bases       = r_bases;
    assign o_outs        = r_outs;
    assign o_inning      = r_inning;
    assign o_bottom      = r_bottom;
    assign o_score_away  = r_away;
    assign o_score_home  = r_home;
    assign o_side_change = r_side;
    assign o_game_over   = r_over;
    assign o_bad_input   = r_bad;

endmodule
